// File: rtl/cordic_periph_pkg.sv
// Shared definitions for the sine/cosine register front end: register offsets,
// STATUS bit positions and the sequencing states.
package cordic_periph_pkg;

  localparam logic [3:0] ADDR_ARG_SIN = 4'h0;
  localparam logic [3:0] ADDR_ARG_COS = 4'h4;
  localparam logic [3:0] ADDR_RESULT  = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  // Same positions are used for STATUS reads and for STATUS write commands.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IE   = 2;
  localparam int STAT_OVR  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_periph.sv
// CPU register front end for the FP sine/cosine stage: latches the angle, pulses start,
// captures the result on done, stalls RESULT reads while busy and raises a maskable IRQ.
module cordic_periph
  import cordic_periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [31:0] cordic_dataa,
  output logic        cordic_cos,
  output logic        cordic_start,
  output logic        cordic_clk_en,
  input  logic        cordic_done,
  input  logic [31:0] cordic_result
);

  localparam logic [1:0] SEL_ARG_SIN = ADDR_ARG_SIN[3:2];
  localparam logic [1:0] SEL_ARG_COS = ADDR_ARG_COS[3:2];
  localparam logic [1:0] SEL_RESULT  = ADDR_RESULT[3:2];
  localparam logic [1:0] SEL_STATUS  = ADDR_STATUS[3:2];

  state_t      state_q, state_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] res_q, res_d;
  logic        cos_q, cos_d;
  logic        done_q, done_d;
  logic        ie_q, ie_d;
  logic        ovr_q, ovr_d;
  logic        irq_q;

  logic [1:0]  sel;
  logic        unused_addr_lsb;
  logic        rd_req, wr_any, wr_word;
  logic        busy, arg_wr, status_wr, res_rd, capture;
  logic [31:0] status_word;

  // Low address bits are ignored: a misaligned word write hits the register at [3:2].
  assign sel             = address[3:2];
  assign unused_addr_lsb = ^address[1:0];

  assign rd_req    = (data_read_n != 2'b11);
  assign wr_any    = (data_write_n != 2'b11);
  assign wr_word   = (data_write_n == 2'b10);

  assign busy      = (state_q != IDLE);
  assign arg_wr    = wr_word && ((sel == SEL_ARG_SIN) || (sel == SEL_ARG_COS));
  assign status_wr = wr_any && (sel == SEL_STATUS);
  assign res_rd    = rd_req && (sel == SEL_RESULT) && !busy;
  assign capture   = (state_q == BUSY) && cordic_done;

  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    res_d   = res_q;
    cos_d   = cos_q;
    done_d  = done_q;
    ie_d    = ie_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (arg_wr) begin
          state_d = START;
          arg_d   = data_in;
          cos_d   = (sel == SEL_ARG_COS);
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (cordic_done) begin
          state_d = IDLE;
          res_d   = cordic_result;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arg_wr && busy) ovr_d = 1'b1;

    if (status_wr) begin
      ie_d = data_in[STAT_IE];
      if (data_in[STAT_OVR])  ovr_d  = 1'b0;
      if (data_in[STAT_DONE]) done_d = 1'b0;
    end

    if (res_rd)  done_d = 1'b0;
    // Capture is applied last so a same-cycle clear cannot lose a completion.
    if (capture) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arg_q   <= 32'h0;
      res_q   <= 32'h0;
      cos_q   <= 1'b0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      res_q   <= res_d;
      cos_q   <= cos_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      ovr_q   <= ovr_d;
      irq_q   <= done_q & ie_q;
    end
  end

  assign status_word = {28'h0, ovr_q, ie_q, done_q, busy};

  always_comb begin
    data_out = 32'h0;
    case (sel)
      SEL_ARG_SIN: data_out = arg_q;
      SEL_ARG_COS: data_out = arg_q;
      SEL_RESULT:  data_out = res_q;
      SEL_STATUS:  data_out = status_word;
      default:     data_out = 32'h0;
    endcase
  end

  assign data_ready     = rd_req && !((sel == SEL_RESULT) && busy);
  assign user_interrupt = irq_q;
  assign cordic_dataa   = arg_q;
  assign cordic_cos     = cos_q;
  assign cordic_start   = (state_q == START);
  assign cordic_clk_en  = 1'b1;

endmodule
